// File: rtl/wall_probe_arbiter.sv
// Shares one Walls ROM read port among NUM_REQ movers (Pac-Man and ghosts).
// Grants one mover at a time with round-robin priority and runs four
// wall probes (up, left, down, right) around its sprite. The mover then
// receives a 4-bit blocked mask with a one-cycle done pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no probe in flight; picks the next requester round-robin
// S_ISSUE | drives one probe row address per cycle, 4 cycles
// S_DRAIN | waits ROM_LATENCY cycles for the last probe data to arrive
// S_DONE  | one cycle; done/grant/blocked presented to the mover
module wall_probe_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SPRITE_SIZE = 16,
    parameter int ROM_LATENCY = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_REQ-1:0]      i_req,
    input  logic [NUM_REQ*10-1:0]   i_req_x,
    input  logic [NUM_REQ*10-1:0]   i_req_y,
    output logic [8:0]              o_rom_addr,
    input  logic [639:0]            i_rom_data,
    output logic [NUM_REQ-1:0]      o_grant,
    output logic                    o_done,
    output logic [3:0]              o_blocked,
    output logic                    o_busy
);

    localparam int          IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [10:0] C_SIZE = 11'(SPRITE_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_cnt;
    logic [IW-1:0]        r_rr_ptr;
    logic [10:0]          r_x;
    logic [10:0]          r_y;
    logic [3:0]           r_shadow;
    logic                 r_done;
    logic [NUM_REQ-1:0]   r_grant;
    logic [3:0]           r_blocked;

    logic                 w_win_valid;
    logic [IW-1:0]        w_win_idx;
    logic [9:0]           w_win_x;
    logic [9:0]           w_win_y;
    logic                 w_iss_forced;
    logic [8:0]           w_iss_row;
    logic [3:0]           w_rel;
    logic                 w_cap_en;
    logic [1:0]           w_cap_ph;
    logic                 w_cap_forced;
    logic [10:0]          w_cap_col;
    logic                 w_cap_bit;
    logic [3:0]           w_shadow_nxt;

    // A probe that would leave the 640x480 field is treated as a wall
    // without consulting the ROM.
    function automatic logic f_forced(input logic [1:0] ph,
                                      input logic [10:0] x,
                                      input logic [10:0] y);
        logic f;
        case (ph)
            2'd0:    f = (y == 11'd0);
            2'd1:    f = (x == 11'd0);
            2'd2:    f = ((y + C_SIZE) > 11'd479);
            default: f = ((x + C_SIZE) > 11'd639);
        endcase
        f_forced = f;
    endfunction

    // Round-robin pick: lowest set request above the pointer, else lowest overall.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_win_x     = '0;
        w_win_y     = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (i_req[j] && !w_win_valid && (j > int'(r_rr_ptr))) begin
                w_win_valid = 1'b1;
                w_win_idx   = IW'(j);
                w_win_x     = i_req_x[10*j +: 10];
                w_win_y     = i_req_y[10*j +: 10];
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (i_req[j] && !w_win_valid) begin
                w_win_valid = 1'b1;
                w_win_idx   = IW'(j);
                w_win_x     = i_req_x[10*j +: 10];
                w_win_y     = i_req_y[10*j +: 10];
            end
        end
    end

    // Row address for the probe being issued this cycle; forced probes drive 0.
    always_comb begin
        w_iss_forced = f_forced(r_cnt[1:0], r_x, r_y);
        case (r_cnt[1:0])
            2'd0:    w_iss_row = 9'(r_y - 11'd1);
            2'd2:    w_iss_row = 9'(r_y + C_SIZE);
            default: w_iss_row = 9'(r_y);
        endcase
        o_rom_addr = '0;
        if ((r_state == S_ISSUE) && !w_iss_forced) begin
            o_rom_addr = w_iss_row;
        end
    end

    // Capture lags issue by ROM_LATENCY; w_rel is the phase whose data is on the bus now.
    always_comb begin
        w_rel        = {1'b0, r_cnt} - 4'(ROM_LATENCY);
        w_cap_ph     = w_rel[1:0];
        w_cap_en     = ((r_state == S_ISSUE) || (r_state == S_DRAIN)) &&
                       !w_rel[3] && !w_rel[2];
        w_cap_forced = f_forced(w_cap_ph, r_x, r_y);
        case (w_cap_ph)
            2'd1:    w_cap_col = r_x - 11'd1;
            2'd3:    w_cap_col = r_x + C_SIZE;
            default: w_cap_col = r_x;
        endcase
        // Columns beyond the row width only occur for off-field movers; read them as wall.
        if (w_cap_forced || (w_cap_col > 11'd639)) begin
            w_cap_bit = 1'b1;
        end else begin
            w_cap_bit = i_rom_data[w_cap_col[9:0]];
        end
        w_shadow_nxt = r_shadow;
        if (w_cap_en) begin
            w_shadow_nxt[w_cap_ph] = w_cap_bit;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_cnt == 3'd3) begin
                    w_state_nxt = (ROM_LATENCY == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_cnt == 3'(ROM_LATENCY + 3)) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winner, step the phase counter, build the mask, publish the result.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_rr_ptr  <= IW'(NUM_REQ - 1);
            r_x       <= '0;
            r_y       <= '0;
            r_shadow  <= '0;
            r_done    <= 1'b0;
            r_grant   <= '0;
            r_blocked <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_rr_ptr <= w_win_idx;
                        r_x      <= {1'b0, w_win_x};
                        r_y      <= {1'b0, w_win_y};
                        r_cnt    <= '0;
                        r_shadow <= '0;
                    end
                end
                S_ISSUE, S_DRAIN: begin
                    r_cnt    <= r_cnt + 3'd1;
                    r_shadow <= w_shadow_nxt;
                    if (w_state_nxt == S_DONE) begin
                        r_done    <= 1'b1;
                        r_grant   <= NUM_REQ'(1) << r_rr_ptr;
                        r_blocked <= w_shadow_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_done    = r_done;
    assign o_grant   = r_grant;
    assign o_blocked = r_blocked;
    assign o_busy    = (r_state != S_IDLE);

endmodule
